// File: rtl/gate_checker.sv
// Gate checker: walks every input vector of a 1- or 2-input gate, waits for the
// response to settle, and compares it against the selected logic function.
module gate_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a_o,
  output logic       b_o,
  input  logic       s_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StSample, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [1:0] fv_q, fv_d;

  logic       expected;
  logic       mismatch;
  logic [1:0] last_idx;

  function automatic logic gate_eval(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0:    gate_eval = ~a;
      3'd1:    gate_eval = a & b;
      3'd2:    gate_eval = a | b;
      3'd3:    gate_eval = ~(a & b);
      3'd4:    gate_eval = ~(a | b);
      3'd5:    gate_eval = a ^ b;
      3'd6:    gate_eval = ~(a ^ b);
      default: gate_eval = 1'b0;
    endcase
  endfunction

  assign expected = gate_eval(op_q, a_q, b_q);
  assign mismatch = (s_i != expected);
  // NOT exercises only a, so it has two vectors instead of four.
  assign last_idx = (op_q == 3'd0) ? 2'd1 : 2'd3;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    case (state_q)
      StIdle, StDone: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          op_d    = op;
          idx_d   = 2'd0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fv_d    = 2'd0;
          state_d = (op == 3'd7) ? StDone : StDrive;
        end else begin
          state_d = StIdle;
        end
      end
      StDrive: begin
        a_d     = idx_q[0];
        b_d     = (op_q == 3'd0) ? 1'b0 : idx_q[1];
        cnt_d   = 4'd0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (mismatch) begin
          if (err_q != 3'd4) err_d = err_q + 3'd1;
          if (err_q == 3'd0) fv_d = idx_q;
        end
        if (idx_q == last_idx) begin
          pass_d  = !mismatch && (err_q == 3'd0);
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fv_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = (state_q == StDrive) || (state_q == StWait) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: stimulus queues expected results, a monitor
// checks them against every done pulse.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic       a_o, b_o, s_i;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;

  int          mode;   // 0 good gate, 1 s=a, 2 s=a|b, 3 inverted gate
  logic [2:0]  tb_op;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        p;
    logic [2:0]  e;
    logic [1:0]  f;
    int unsigned c;
  } exp_t;
  exp_t sb[$];

  gate_checker #(.SETTLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a_o       (a_o),
    .b_o       (b_o),
    .s_i       (s_i),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_ref(input logic [2:0] o, input logic a, input logic b);
    case (o)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (mode)
      1:       s_i = a_o;
      2:       s_i = a_o | b_o;
      3:       s_i = ~gate_ref(tb_op, a_o, b_o);
      default: s_i = gate_ref(tb_op, a_o, b_o);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pass", 32'(pass), 32'(e.p));
        check("err_count", 32'(err_count), 32'(e.e));
        check("fail_vec", 32'(fail_vec), 32'(e.f));
        check("done_cycle", cyc, e.c);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  // Caller is at a negedge; start is accepted on the next rising edge.
  task automatic issue(input logic [2:0] o, input int m, input logic p, input logic [2:0] e,
                       input logic [1:0] f, input int unsigned lat);
    op    = o;
    tb_op = o;
    mode  = m;
    start = 1'b1;
    sb.push_back('{p: p, e: e, f: f, c: cyc + lat});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input int m, input logic p, input logic [2:0] e,
                     input logic [1:0] f, input int unsigned lat);
    @(negedge clk);
    issue(o, m, p, e, f, lat);
    wait_done(lat + 4);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    tb_op = 3'd0;
    mode  = 0;
    #1;
    check("reset_outputs", 32'({a_o, b_o, busy, done, pass, err_count, fail_vec}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // NOT, good gate: a_o walks 0,1 with b_o held 0; done in cycle 7.
    @(negedge clk);
    issue(3'd0, 0, 1'b1, 3'd0, 2'd0, 7);
    @(negedge clk);  // cycle 1
    check("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);  // cycle 2, WAIT of vector 0
    check("not_vec0_a", 32'({a_o, b_o}), 32'b00);
    repeat (3) @(negedge clk);  // cycle 5, WAIT of vector 1
    check("not_vec1_a", 32'({a_o, b_o}), 32'b10);
    wait_done(6);
    @(negedge clk);
    check("idle_ab_cleared", 32'({a_o, b_o, busy, done}), 32'd0);

    run(3'd0, 1, 1'b0, 3'd2, 2'd0, 7);   // NOT as buffer: both vectors wrong
    run(3'd5, 2, 1'b0, 3'd1, 2'd3, 13);  // XOR modelled as OR: only vector 3 fails
    run(3'd2, 1, 1'b0, 3'd1, 2'd2, 13);  // OR modelled as s=a: vector 2 fails
    run(3'd1, 2, 1'b0, 3'd2, 2'd1, 13);  // AND modelled as OR: vectors 1,2 fail
    run(3'd4, 3, 1'b0, 3'd4, 2'd0, 13);  // NOR inverted: all four fail
    run(3'd3, 0, 1'b1, 3'd0, 2'd0, 13);  // NAND good

    // Reserved op: done right after the start edge, stimulus stays 0.
    @(negedge clk);
    issue(3'd7, 0, 1'b0, 3'd0, 2'd0, 1);
    @(negedge clk);
    check("op7_done", 32'(done), 32'd1);
    check("op7_ab", 32'({a_o, b_o}), 32'd0);
    @(negedge clk);
    check("op7_back_idle", 32'({a_o, b_o, busy, done}), 32'd0);

    // AND aborted by reset during WAIT of vector 2.
    @(negedge clk);
    issue(3'd1, 0, 1'b1, 3'd0, 2'd0, 13);
    repeat (8) @(negedge clk);  // cycle 8
    check("and_vec2_ab", 32'({a_o, b_o}), 32'b01);
    check("and_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({a_o, b_o, busy, done, pass, err_count, fail_vec}), 32'd0);
    sb.delete();
    @(negedge clk);
    // Start already present on the first edge after reset release.
    rst_n = 1'b1;
    issue(3'd1, 0, 1'b1, 3'd0, 2'd0, 13);
    wait_done(17);
    @(negedge clk);

    // XNOR with start held: back-to-back sequences, results cleared at the restart edge.
    @(negedge clk);
    op    = 3'd6;
    tb_op = 3'd6;
    mode  = 0;
    start = 1'b1;
    sb.push_back('{p: 1'b1, e: 3'd0, f: 2'd0, c: cyc + 13});
    sb.push_back('{p: 1'b1, e: 3'd0, f: 2'd0, c: cyc + 26});
    wait_done(20);
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_cleared", 32'({pass, err_count, fail_vec}), 32'd0);
    start = 1'b0;
    wait_done(20);
    @(negedge clk);
    check("final_idle", 32'({busy, done}), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
